// File: rtl/pseudo.sv
// rtl/pseudo.sv - 8-bit LFSR pseudo-random generator with edge-triggered runs
//
// pseudo ports:
//   clk      in   1  single clock, rising edge
//   rst      in   1  synchronous active-high reset
//   start    in   1  run request, 0->1 edge triggers a run while idle
//   sw_in    in   8  seed, sampled on the trigger edge
//   seq_num  in   8  number of LFSR steps, sampled on the trigger edge
//   num      out  8  registered result of the last completed run
//   busy     out  1  high while a run is in progress
// pseudo_stim ports:
//   sw_in    out  8  constant seed 8'hA5
//   seq_num  out  8  constant step count 8'h03
// Optional build macro: PSEUDO_ZERO_GUARD_EN (zero seed replaced by 8'h01 at load)

module pseudo (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] sw_in,
    input  logic [7:0] seq_num,
    output logic [7:0] num,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] num_q, num_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d;

    logic [7:0] seed_load;
    logic       trigger;
    logic       feedback;

`ifdef PSEUDO_ZERO_GUARD_EN
    // An all-zero LFSR never leaves zero, so steer it onto the sequence.
    assign seed_load = (sw_in == 8'h00) ? 8'h01 : sw_in;
`else
    assign seed_load = sw_in;
`endif

    assign trigger  = (state_q == ST_IDLE) && start && !start_q;
    // Taps for x^8+x^6+x^5+x^4+1 in this shift-left arrangement.
    assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        busy_d  = busy_q;
        start_d = start;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    lfsr_d  = seed_load;
                    cnt_d   = seq_num;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q != 8'h00) begin
                    lfsr_d = {lfsr_q[6:0], feedback};
                    cnt_d  = cnt_q - 8'h01;
                end else begin
                    num_d   = lfsr_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= 8'h00;
            cnt_q   <= 8'h00;
            num_q   <= 8'h00;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign num  = num_q;
    assign busy = busy_q;

endmodule

module pseudo_stim (
    output logic [7:0] sw_in,
    output logic [7:0] seq_num
);

    assign sw_in   = 8'hA5;
    assign seq_num = 8'h03;

endmodule

// File: tb/tb_pseudo.sv
// tb/tb_pseudo.sv - self-checking bench for pseudo with run-level reference model

module tb_pseudo;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] sw_in;
    logic [7:0] seq_num;
    logic [7:0] num;
    logic       busy;
    logic [7:0] stim_sw;
    logic [7:0] stim_seq;

    int checks = 0;
    int errors = 0;

    pseudo dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sw_in  (sw_in),
        .seq_num(seq_num),
        .num    (num),
        .busy   (busy)
    );

    pseudo_stim stim (
        .sw_in  (stim_sw),
        .seq_num(stim_seq)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_run(input logic [7:0] s, input int n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
        return v;
    endfunction

    function automatic logic [7:0] load_val(input logic [7:0] s);
`ifdef PSEUDO_ZERO_GUARD_EN
        return (s == 8'h00) ? 8'h01 : s;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run-level model: a run occupies seq_num+1 busy cycles, then publishes its result.
    int         m_left  = 0;
    logic [7:0] m_num   = 8'h00;
    logic [7:0] m_pending = 8'h00;
    logic       m_prev  = 1'b0;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left  = 0;
            m_num   = 8'h00;
            m_prev  = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_num = m_pending;
            end else if (start && !m_prev) begin
                m_left    = int'(seq_num) + 1;
                m_pending = lfsr_run(load_val(sw_in), int'(seq_num));
            end
            m_prev = start;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("cyc_num", {24'd0, num}, {24'd0, m_num});
        end
    end

    task automatic do_run(input logic [7:0] seed, input logic [7:0] n,
                          input logic [7:0] exp_num, input int exp_busy, input string tag);
        int cnt;
        @(negedge clk);
        sw_in   = seed;
        seq_num = n;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 400) chk({tag, "_timeout"}, 32'd1, 32'd0);
        chk({tag, "_busy_cycles"}, cnt, exp_busy);
        chk({tag, "_num"}, {24'd0, num}, {24'd0, exp_num});
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; sw_in = 8'h00; seq_num = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_num", {24'd0, num}, 32'h00);
        rst = 1'b0;

        // Pin the model's step function to hand-computed values.
        chk("model_a5_1", {24'd0, lfsr_run(8'hA5, 1)}, 32'h4A);
        chk("model_a5_2", {24'd0, lfsr_run(8'hA5, 2)}, 32'h95);
        chk("model_01_5", {24'd0, lfsr_run(8'h01, 5)}, 32'h23);

        do_run(stim_sw, stim_seq, 8'h2A, 4, "stim");
        do_run(8'h01, 8'd8, 8'h1C, 9, "s01_n8");
        do_run(8'h01, 8'd4, 8'h11, 5, "s01_n4");
        do_run(8'h5A, 8'd0, 8'h5A, 1, "s5a_n0");
        do_run(8'h01, 8'd255, 8'h01, 256, "s01_n255");

        // Start toggles and input churn during a run must not affect it.
        @(negedge clk);
        sw_in = 8'h01; seq_num = 8'd8; start = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            start   = (cnt >= 7) ? 1'b1 : cnt[0];
            sw_in   = 8'($urandom);
            seq_num = 8'($urandom);
            @(negedge clk);
        end
        chk("toggle_busy_cycles", cnt, 9);
        chk("toggle_num", {24'd0, num}, 32'h1C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_start_busy", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;

`ifdef PSEUDO_ZERO_GUARD_EN
        do_run(8'h00, 8'd4, 8'h11, 5, "zero_seed");
`else
        do_run(8'h00, 8'd4, 8'h00, 5, "zero_seed");
`endif

        // Reset in the second RUN cycle abandons the run.
        @(negedge clk);
        sw_in = 8'h01; seq_num = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_num", {24'd0, num}, 32'h00);
        rst = 1'b0;
        do_run(8'hA5, 8'd3, 8'h2A, 4, "after_rst");

        // Reset and a start edge together: reset wins.
        @(negedge clk);
        sw_in = 8'h01; seq_num = 8'd2; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
